sprite_line_fetcher: RTL

//  Reader side of the sprite ROM interface. In horizontal blanking it walks NUM_SLOTS sprite slots and finds those that intersect the next scanline.
//  For each hit it reads one 8-bit row from the ROM and latches it into a shadow line buffer.
//  At the start of active video the shadow buffer is swapped into the active buffer, which is then rendered per pixel.

---
 rtl/sprite_line_fetcher.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/sprite_line_fetcher.sv
// sprite_line_fetcher
//   Scanline sprite fetch and render. During horizontal blanking, one slot is
//   visited per cycle. Each slot that intersects next_line has one ROM row
//   latched into a shadow line buffer. On line_swap, a completed shadow buffer
//   becomes the active buffer. The active buffer is rendered against pixel_x
//   with one cycle of latency.
//
// Ports
//   clk, reset          pixel clock, asynchronous active-low reset
//   line_start          pulse: begin fetching for next_line (also restarts a fetch)
//   next_line           y of the scanline being fetched
//   line_swap           pulse: shadow -> active at start of active video
//   slot_valid/x/y/id/orient  packed per-slot attributes, slot i at [W*i +: W]
//   rom_read_enable, rom_sprite_ID, rom_line_index, rom_orientation  ROM request
//   rom_data            active-low ROM row (0 = pixel on), combinational from rom_*
//   pixel_x, video_active  render position and visible-area qualifier
//   pixel_on, pixel_slot   registered render result for the previous pixel_x
//   fetch_busy, fetch_done fetch status (busy while walking slots, done pulse)
module sprite_line_fetcher #(
  parameter int unsigned NUM_SLOTS  = 4,
  parameter int unsigned SCALE_LOG2 = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    line_start,
  input  logic [9:0]              next_line,
  input  logic                    line_swap,
  input  logic [NUM_SLOTS-1:0]    slot_valid,
  input  logic [10*NUM_SLOTS-1:0] slot_x,
  input  logic [10*NUM_SLOTS-1:0] slot_y,
  input  logic [4*NUM_SLOTS-1:0]  slot_id,
  input  logic [2*NUM_SLOTS-1:0]  slot_orient,
  output logic                    rom_read_enable,
  output logic [3:0]              rom_sprite_ID,
  output logic [2:0]              rom_line_index,
  output logic [1:0]              rom_orientation,
  input  logic [7:0]              rom_data,
  input  logic [9:0]              pixel_x,
  input  logic                    video_active,
  output logic                    pixel_on,
  output logic [1:0]              pixel_slot,
  output logic                    fetch_busy,
  output logic                    fetch_done
);

  localparam int unsigned CntW = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  localparam logic [CntW-1:0] LastSlot = CntW'(NUM_SLOTS - 1);
  // Sprite extent in screen pixels, in both x and y.
  localparam logic [9:0] Span = 10'(8 << SCALE_LOG2);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StFetch = 2'd1;
  localparam logic [1:0] StDone  = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [CntW-1:0] slot_cnt_q, slot_cnt_d;
  logic            complete_q, complete_d;

  logic [7:0]           shadow_row_q [NUM_SLOTS];
  logic [NUM_SLOTS-1:0] shadow_hit_q;
  logic [7:0]           active_row_q [NUM_SLOTS];
  logic [NUM_SLOTS-1:0] active_hit_q;

  logic       pixel_on_q;
  logic [1:0] pixel_slot_q;

  // Unpacked views of the packed slot buses.
  logic [9:0] x_arr      [NUM_SLOTS];
  logic [9:0] y_arr      [NUM_SLOTS];
  logic [3:0] id_arr     [NUM_SLOTS];
  logic [1:0] orient_arr [NUM_SLOTS];

  always_comb begin
    for (int i = 0; i < NUM_SLOTS; i++) begin
      x_arr[i]      = slot_x[10*i +: 10];
      y_arr[i]      = slot_y[10*i +: 10];
      id_arr[i]     = slot_id[4*i +: 4];
      orient_arr[i] = slot_orient[2*i +: 2];
    end
  end

  // Fetch datapath: the slot under slot_cnt_q is evaluated against next_line.
  logic       fetching;
  logic [9:0] dy;
  logic       fetch_hit;

  assign fetching  = (state_q == StFetch);
  assign dy        = next_line - y_arr[slot_cnt_q];
  assign fetch_hit = fetching && slot_valid[slot_cnt_q] && (dy < Span);

  always_comb begin
    rom_read_enable = fetch_hit;
    rom_sprite_ID   = '0;
    rom_line_index  = '0;
    rom_orientation = '0;
    if (fetching) begin
      rom_sprite_ID   = id_arr[slot_cnt_q];
      rom_line_index  = 3'(dy >> SCALE_LOG2);
      rom_orientation = orient_arr[slot_cnt_q];
    end
  end

  assign fetch_busy = fetching;
  assign fetch_done = (state_q == StDone);

  always_comb begin
    state_d    = state_q;
    slot_cnt_d = slot_cnt_q;
    complete_d = complete_q;
    unique case (state_q)
      StIdle: ;
      StFetch: begin
        if (slot_cnt_q == LastSlot) begin
          state_d = StDone;
        end else begin
          slot_cnt_d = slot_cnt_q + 1'b1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    // A consumed shadow buffer must not be swapped in twice.
    if (line_swap && complete_q) begin
      complete_d = 1'b0;
    end
    if (state_q == StDone) begin
      complete_d = 1'b1;
    end
    // Restart wins over everything, including a DONE in the same cycle.
    if (line_start) begin
      state_d    = StFetch;
      slot_cnt_d = '0;
      complete_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      slot_cnt_q <= '0;
      complete_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      slot_cnt_q <= slot_cnt_d;
      complete_q <= complete_d;
    end
  end

  // Line buffers. The swap reads the current (pre-restart) shadow contents.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        shadow_row_q[i] <= 8'hFF;
        active_row_q[i] <= 8'hFF;
      end
      shadow_hit_q <= '0;
      active_hit_q <= '0;
    end else begin
      if (line_start) begin
        shadow_hit_q <= '0;
      end else if (fetch_hit) begin
        shadow_row_q[slot_cnt_q] <= rom_data;
        shadow_hit_q[slot_cnt_q] <= 1'b1;
      end
      if (line_swap) begin
        if (complete_q) begin
          for (int i = 0; i < NUM_SLOTS; i++) begin
            active_row_q[i] <= shadow_row_q[i];
          end
          active_hit_q <= shadow_hit_q;
        end else begin
          // Fetch did not finish in time: show a blank line.
          active_hit_q <= '0;
        end
      end
    end
  end

  // Render: per-slot hit test, lowest lit index wins.
  logic [9:0]           dx  [NUM_SLOTS];
  logic [2:0]           col [NUM_SLOTS];
  logic [NUM_SLOTS-1:0] lit;
  logic [1:0]           win;
  logic                 pixel_on_d;

  always_comb begin
    lit = '0;
    win = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      dx[i]  = pixel_x - x_arr[i];
      col[i] = 3'(dx[i] >> SCALE_LOG2);
      // Column 0 is bit 7; ROM data is active-low.
      lit[i] = active_hit_q[i] && (dx[i] < Span) && !active_row_q[i][3'd7 - col[i]];
    end
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (lit[i]) begin
        win = 2'(i);
      end
    end
  end

  assign pixel_on_d = video_active && (|lit);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pixel_on_q   <= 1'b0;
      pixel_slot_q <= '0;
    end else begin
      pixel_on_q   <= pixel_on_d;
      pixel_slot_q <= pixel_on_d ? win : 2'd0;
    end
  end

  assign pixel_on   = pixel_on_q;
  assign pixel_slot = pixel_slot_q;

endmodule
